// File: rtl/encoder_4_2_sync_if.sv
// Request/index bundle between event sources, the 4-to-2 encoder and its consumer.
// master drives requests and ack; slave (the encoder) returns the index and status.
interface encoder_4_2_sync_if;
  logic       en;
  logic [3:0] y_in;
  logic       ack;
  logic [1:0] x;
  logic       valid;
  logic       multi;
  logic [3:0] pending;

  modport master (
    output en, y_in, ack,
    input  x, valid, multi, pending
  );

  modport slave (
    input  en, y_in, ack,
    output x, valid, multi, pending
  );
endinterface

// File: rtl/encoder_4_2_sync.sv
// Registered 4-to-2 priority encoder: requests coalesce into a pending register; index held until ack.
// Latency 2 edges request-to-valid; one index per clk while ack=1, x frozen while ack=0.
module encoder_4_2_sync #(
  parameter int NREQ       = 4,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  encoder_4_2_sync_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [IDX_W-1:0]  x_q;
  logic [IDX_W-1:0]  x_nxt;
  logic [NREQ-1:0]   pending_q;
  logic [NREQ-1:0]   pending_nxt;
  logic [NREQ-1:0]   clr_mask;
  logic [NREQ-1:0]   rest;
  logic [NREQ-1:0]   cap;
  logic              multi_q;
  logic              multi_nxt;

  function automatic logic [IDX_W-1:0] prio_enc(input logic [NREQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // Last match wins, so the scan direction sets the priority order.
    if (HIGH_FIRST) begin
      for (int i = 0; i < NREQ; i++)
        if (v[i]) idx = i[IDX_W-1:0];
    end else begin
      for (int i = NREQ - 1; i >= 0; i--)
        if (v[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

  function automatic logic [NREQ-1:0] bit_of(input logic [IDX_W-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic int popcount(input logic [NREQ-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NREQ; i++)
      cnt = cnt + int'(v[i]);
    return cnt;
  endfunction

  assign cap = bus.en ? bus.y_in : '0;

  always_comb begin
    state_nxt = state_q;
    x_nxt     = x_q;
    clr_mask  = '0;
    rest      = pending_q & ~bit_of(x_q);
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          x_nxt     = prio_enc(pending_q);
          clr_mask  = bit_of(prio_enc(pending_q));
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          if (|rest) begin
            x_nxt    = prio_enc(rest);
            clr_mask = bit_of(prio_enc(rest));
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Set after clear: a fresh request for the bit being loaded stays pending.
    pending_nxt = (pending_q & ~clr_mask) | cap;
    multi_nxt   = bus.en && (popcount(bus.y_in) >= 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      pending_q <= '0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      x_q       <= x_nxt;
      pending_q <= pending_nxt;
      multi_q   <= multi_nxt;
    end
  end

  assign bus.x       = x_q;
  assign bus.valid   = (state_q == HOLD);
  assign bus.multi   = multi_q;
  assign bus.pending = pending_q;

endmodule

// File: doc/encoder_4_2_sync.md
Name: encoder_4_2_sync

Overview:
- Registered 4-to-2 priority encoder with request capture and a valid/ack output handshake; it is the inverse of the 2-to-4 decoder_2_4.
- Captures request lines y_in[3:0] into a pending register, encodes the highest-priority pending line to a 2-bit index, and holds that index until the consumer acknowledges it.
- Sits between event sources (switches, decoder outputs) and any logic that consumes an encoded 2-bit select.

Parameters:
- NREQ, 4, number of request lines. Fixed at 4; x is 2 bits wide.
- HIGH_FIRST, 1, priority order. 1 = bit 3 highest priority; 0 = bit 0 highest.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  capture enable. When 0, y_in is ignored.
- y_in  input  4  request lines, sampled every clk edge while en=1.
- ack  input  1  consumer accepts the current index when ack=1 and valid=1.
- x  output  2  encoded index of the request being presented.
- valid  output  1  x holds a request awaiting ack.
- multi  output  1  one-cycle pulse: the previous sample had more than one bit set.
- pending  output  4  pending request bits, for debug and status.

Behaviour:
- Reset, at a clk edge with rst=1: pending=4'b0000, x=2'b00, valid=0, multi=0, FSM=IDLE. Reset overrides every other input in that cycle, including a mid-handshake reset.
- Capture, every edge:
  - pending_next = (pending & ~clr_mask) | (en ? y_in : 4'b0000).
  - clr_mask is the one-hot bit of the index being loaded into x this cycle.
  - Set wins over clear: a request for the bit being loaded in the same cycle stays pending.
- FSM states:
  - IDLE (valid=0): if pending != 0, load x = priority_encode(pending), set that bit in clr_mask, valid<=1, go to HOLD. Otherwise stay in IDLE with x unchanged.
  - HOLD (valid=1): x is stable while ack=0.
  - HOLD with ack=1 and (pending & ~bit(x)) != 0: load the next index in the same edge (back-to-back), stay in HOLD, valid stays 1.
  - HOLD with ack=1 and no other pending bit: valid<=0, go to IDLE. x keeps its last value.
- Encoding uses only the pending register, never same-cycle y_in.
- Latency: y_in sampled at edge n gives valid=1 with x valid after edge n+1. Minimum request-to-valid is 2 edges.
- Throughput: one index per clk while ack is held at 1.
- Priority: with HIGH_FIRST=1, 4'b1010 encodes to 3 first, then 1. With HIGH_FIRST=0, the order is 1 then 3.
- Duplicates: a request for a bit already pending merges into it. No counting and no overflow; coalescing is the intended behaviour.
- multi: registered. It is 1 for exactly the one cycle after an edge where en=1 and popcount(y_in) >= 2; otherwise 0. It does not affect capture.
- ack while valid=0 is ignored.
- en=0 while requests are pending: the pending bits still drain through the handshake.
- Encoding is purely a function of the pending register; there are no combinational paths from y_in to x or valid.

Test Plan:
1. Reset then single request: rst=1 for 2 cycles; en=1, y_in=4'b0100 for 1 cycle, then 0; ack=0 → valid=1 with x=2 two edges after the sample, held; ack=1 for one cycle → valid=0 next edge, pending=0.
2. Priority and back-to-back drain: en=1, y_in=4'b1011 for one cycle, ack held at 1 → multi pulses once; x sequence 3,1,0 on consecutive cycles with valid=1; then valid=0. With HIGH_FIRST=0 the sequence is 0,1,3.
3. Enable gating: en=0, y_in=4'b1111 for 5 cycles → pending=0, valid=0, multi=0. Then en=1 for 1 cycle → pending=4'b1111 next edge.
4. Set-wins collision: pending=4'b0010, FSM in IDLE, y_in=4'b0010 with en=1 on the load edge → x=1, valid=1, pending still 4'b0010. After ack, x=1 is presented a second time.
5. Hold stability: valid=1, x=2, ack=0 for 10 cycles while y_in=4'b1000 arrives → x stays 2. After ack, x=3 on the next edge.
6. Reset mid-operation: valid=1, pending=4'b1001, assert rst for 1 cycle with ack=1 and y_in=4'b0110 → all outputs 0 at the next edge and nothing captured.
